// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU front end: fetch FSM states and
// default datapath widths.
package cpu8_pkg;

   localparam int CPU8_ADDR_W   = 8;
   localparam int CPU8_DATA_W   = 8;
   // Opcode bit that marks a two-byte instruction (opcode + operand)
   localparam int CPU8_OPND_BIT = 7;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ_OP   = 3'd1,
      WAIT_OP  = 3'd2,
      REQ_ARG  = 3'd3,
      WAIT_ARG = 3'd4,
      PRESENT  = 3'd5
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register. A load (redirect) wins over the increment in
// the same cycle; arithmetic wraps modulo 2^ADDR_W.
module fetch_pc
   import cpu8_pkg::*;
#(
   parameter int ADDR_W   = CPU8_ADDR_W,
   parameter int RESET_PC = 0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_value,
   input  logic              i_increment,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   // PC update: load has priority, otherwise step by one when asked
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_pc <= ADDR_W'(RESET_PC);
      end else if (i_load) begin
         r_pc <= i_load_value;
      end else if (i_increment) begin
         r_pc <= r_pc + ADDR_W'(1);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads opcode (and operand for two-byte opcodes)
// from a synchronous program memory and presents the complete instruction
// over a valid/ready handshake. All outputs are decoded from state and
// registers only.
module instruction_fetch_unit
   import cpu8_pkg::*;
#(
   parameter int ADDR_W   = CPU8_ADDR_W,
   parameter int DATA_W   = CPU8_DATA_W,
   parameter int RESET_PC = 0,
   parameter int OPND_BIT = CPU8_OPND_BIT
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic              o_instr_valid,
   input  logic              i_instr_ready,
   output logic [DATA_W-1:0] o_instr_opcode,
   output logic [DATA_W-1:0] o_instr_operand,
   output logic [ADDR_W-1:0] o_instr_pc,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_busy
);

   fetch_state_t      r_state;
   fetch_state_t      w_next_state;
   logic [DATA_W-1:0] r_opcode;
   logic [DATA_W-1:0] r_operand;
   logic [ADDR_W-1:0] r_instr_pc;
   logic [ADDR_W-1:0] w_pc;
   logic              w_pc_inc;
   logic              w_cap_op;
   logic              w_cap_arg;

   fetch_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_fetch_pc (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_load       (i_redirect),
      .i_load_value (i_redirect_pc),
      .i_increment  (w_pc_inc),
      .o_pc         (w_pc)
   );

   // FSM state register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and capture strobes; a redirect overrides everything,
   // so memory data returning in the redirect cycle is never captured
   always_comb begin
      w_next_state = r_state;
      w_pc_inc     = 1'b0;
      w_cap_op     = 1'b0;
      w_cap_arg    = 1'b0;
      if (i_redirect) begin
         w_next_state = i_enable ? REQ_OP : IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_enable) w_next_state = REQ_OP;
            end
            REQ_OP: begin
               w_next_state = WAIT_OP;
            end
            WAIT_OP: begin
               w_cap_op     = 1'b1;
               w_pc_inc     = 1'b1;
               w_next_state = i_mem_data[OPND_BIT] ? REQ_ARG : PRESENT;
            end
            REQ_ARG: begin
               w_next_state = WAIT_ARG;
            end
            WAIT_ARG: begin
               w_cap_arg    = 1'b1;
               w_pc_inc     = 1'b1;
               w_next_state = PRESENT;
            end
            PRESENT: begin
               if (i_instr_ready) w_next_state = i_enable ? REQ_OP : IDLE;
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
      end
   end

   // Instruction field capture; fields hold while waiting in PRESENT
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_opcode   <= '0;
         r_operand  <= '0;
         r_instr_pc <= '0;
      end else if (w_cap_op) begin
         r_opcode   <= i_mem_data;
         r_instr_pc <= w_pc;
         if (!i_mem_data[OPND_BIT]) r_operand <= '0;
      end else if (w_cap_arg) begin
         r_operand <= i_mem_data;
      end
   end

   assign o_mem_rd        = (r_state == REQ_OP) || (r_state == REQ_ARG);
   assign o_mem_addr      = o_mem_rd ? w_pc : '0;
   assign o_instr_valid   = (r_state == PRESENT);
   assign o_instr_opcode  = r_opcode;
   assign o_instr_operand = r_operand;
   assign o_instr_pc      = r_instr_pc;
   assign o_busy          = (r_state != IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes expected
// instructions derived from memory contents, a monitor pops on handshakes.
module tb_instruction_fetch_unit;

   typedef struct {
      logic [7:0] op;
      logic [7:0] arg;
      logic [7:0] pc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic [7:0] mem_data = 8'h00;
   logic       instr_valid;
   logic       instr_ready = 1'b0;
   logic [7:0] instr_opcode;
   logic [7:0] instr_operand;
   logic [7:0] instr_pc;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       busy;

   logic [7:0] mem [256];
   exp_t       q[$];
   logic [7:0] model_pc = 8'h00;
   int         total = 0;
   int         bad = 0;
   int         hs = 0;
   bit         rnd_ready = 1'b0;

   logic       prev_hold = 1'b0;
   logic [7:0] hold_op, hold_arg, hold_pc;

   instruction_fetch_unit dut (
      .i_clk           (clk),
      .i_reset         (rst_n),
      .i_enable        (enable),
      .o_mem_addr      (mem_addr),
      .o_mem_rd        (mem_rd),
      .i_mem_data      (mem_data),
      .o_instr_valid   (instr_valid),
      .i_instr_ready   (instr_ready),
      .o_instr_opcode  (instr_opcode),
      .o_instr_operand (instr_operand),
      .o_instr_pc      (instr_pc),
      .i_redirect      (redirect),
      .i_redirect_pc   (redirect_pc),
      .o_busy          (busy)
   );

   always #5 clk = ~clk;

   // synchronous program memory: data one cycle after the read strobe
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference model: walk the program from model_pc, n instructions
   task automatic push_n(int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc = model_pc;
         e.op = mem[model_pc];
         if (e.op[7]) begin
            e.arg    = mem[8'(model_pc + 8'd1)];
            model_pc = model_pc + 8'd2;
         end else begin
            e.arg    = 8'h00;
            model_pc = model_pc + 8'd1;
         end
         q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic set_pc(logic [7:0] a);
      redirect    = 1'b1;
      redirect_pc = a;
      enable      = 1'b0;
      tick();
      redirect = 1'b0;
      model_pc = a;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         if (!busy && !instr_valid) ok = 1'b1;
      end
      chk("idle_reached", int'(ok), 1);
   endtask

   task automatic run_seq(int n, bit rnd);
      int         base;
      logic [7:0] first;
      bit         got, done;
      base  = hs;
      first = model_pc;
      push_n(n);
      rnd_ready = rnd;
      if (!rnd) instr_ready = 1'b1;
      enable = 1'b1;
      got    = 1'b0;
      done   = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         tick();
         if (!got && mem_rd) begin
            chk("first_rd_addr", int'(mem_addr), int'(first));
            got = 1'b1;
         end
         if (hs >= base + n - 1) enable = 1'b0;
         if (hs == base + n && !busy) done = 1'b1;
      end
      chk("seq_done", int'(done), 1);
      chk("q_empty", q.size(), 0);
      rnd_ready = 1'b0;
   endtask

   // Monitor: scoreboard pop on each handshake, hold-stability, reset quiet
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rd_in_reset", int'(mem_rd), 0);
         prev_hold = 1'b0;
      end else begin
         if (instr_valid && prev_hold) begin
            chk("hold_op", int'(instr_opcode), int'(hold_op));
            chk("hold_arg", int'(instr_operand), int'(hold_arg));
            chk("hold_pc", int'(instr_pc), int'(hold_pc));
         end
         if (instr_valid && instr_ready) begin
            hs++;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_instr actual op=%0h pc=%0h expected none", instr_opcode, instr_pc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("instr_op", int'(instr_opcode), int'(e.op));
               chk("instr_arg", int'(instr_operand), int'(e.arg));
               chk("instr_pc", int'(instr_pc), int'(e.pc));
            end
         end
         prev_hold = instr_valid && !instr_ready;
         hold_op   = instr_opcode;
         hold_arg  = instr_operand;
         hold_pc   = instr_pc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit ok;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      #2 rst_n = 1'b0;
      tick();
      tick();
      // reset state
      chk("rst_rd", int'(mem_rd), 0);
      chk("rst_addr", int'(mem_addr), 0);
      chk("rst_valid", int'(instr_valid), 0);
      chk("rst_op", int'(instr_opcode), 0);
      chk("rst_arg", int'(instr_operand), 0);
      chk("rst_ipc", int'(instr_pc), 0);
      chk("rst_busy", int'(busy), 0);

      // one-byte latency and back-to-back throughput from reset PC
      mem[0] = 8'h12;
      mem[1] = 8'h21;
      model_pc = 8'h00;
      push_n(2);
      rst_n = 1'b1;
      enable = 1'b1;
      instr_ready = 1'b1;
      tick();
      chk("t1_rd0", int'(mem_rd), 1);
      chk("t1_addr0", int'(mem_addr), 8'h00);
      tick();
      chk("t1_wait_valid", int'(instr_valid), 0);
      tick();
      chk("t1_valid", int'(instr_valid), 1);
      tick();
      chk("t1_rd1", int'(mem_rd), 1);
      chk("t1_addr1", int'(mem_addr), 8'h01);
      enable = 1'b0;
      wait_idle();
      chk("t1_q_empty", q.size(), 0);

      // two-byte instruction, then continue to confirm pc landed on 0x06
      mem[4] = 8'h85;
      mem[5] = 8'h3C;
      mem[6] = 8'h01;
      set_pc(8'h04);
      run_seq(1, 1'b0);
      run_seq(1, 1'b0);

      // consumer stalls for 4 cycles, then accepts; next fetch follows
      mem[8'h10] = 8'h0A;
      mem[8'h11] = 8'h0B;
      set_pc(8'h10);
      push_n(2);
      instr_ready = 1'b0;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         tick();
         if (instr_valid) ok = 1'b1;
      end
      chk("t3_valid_seen", int'(ok), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_stall_valid", int'(instr_valid), 1);
         chk("t3_stall_rd", int'(mem_rd), 0);
      end
      enable = 1'b1;
      instr_ready = 1'b1;
      tick();
      chk("t3_next_rd", int'(mem_rd), 1);
      chk("t3_next_addr", int'(mem_addr), 8'h11);
      enable = 1'b0;
      wait_idle();
      chk("t3_q_empty", q.size(), 0);

      // redirect during operand wait discards the partial instruction
      mem[8'h20] = 8'h8A;
      mem[8'h21] = 8'h55;
      mem[8'h40] = 8'h03;
      set_pc(8'h20);
      instr_ready = 1'b1;
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (mem_rd && mem_addr == 8'h21) ok = 1'b1;
      end
      chk("t4_arg_rd_seen", int'(ok), 1);
      tick();
      redirect = 1'b1;
      redirect_pc = 8'h40;
      model_pc = 8'h40;
      push_n(1);
      tick();
      redirect = 1'b0;
      enable = 1'b0;
      chk("t4_valid_after", int'(instr_valid), 0);
      chk("t4_rd", int'(mem_rd), 1);
      chk("t4_addr", int'(mem_addr), 8'h40);
      wait_idle();
      chk("t4_q_empty", q.size(), 0);

      // operand address wraps past 0xFF; pc ends at 0x01
      mem[8'hFF] = 8'h90;
      mem[8'h00] = 8'h07;
      mem[8'h01] = 8'h02;
      set_pc(8'hFF);
      run_seq(1, 1'b0);
      run_seq(1, 1'b0);

      // redirect in the same cycle as an accepted handshake
      mem[8'h60] = 8'h11;
      mem[8'h50] = 8'h22;
      set_pc(8'h60);
      push_n(1);
      instr_ready = 1'b0;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         tick();
         if (instr_valid) ok = 1'b1;
      end
      chk("t7_valid_seen", int'(ok), 1);
      base = hs;
      instr_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 8'h50;
      enable = 1'b1;
      tick();
      redirect = 1'b0;
      enable = 1'b0;
      chk("t7_hs_count", hs - base, 1);
      chk("t7_rd", int'(mem_rd), 1);
      chk("t7_addr", int'(mem_addr), 8'h50);
      model_pc = 8'h50;
      push_n(1);
      wait_idle();
      chk("t7_q_empty", q.size(), 0);

      // asynchronous reset while the operand read is issued
      mem[8'h30] = 8'h81;
      set_pc(8'h30);
      instr_ready = 1'b1;
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (mem_rd && mem_addr == 8'h31) ok = 1'b1;
      end
      chk("t6_arg_rd_seen", int'(ok), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rd", int'(mem_rd), 0);
      chk("t6_addr", int'(mem_addr), 0);
      chk("t6_valid", int'(instr_valid), 0);
      chk("t6_op", int'(instr_opcode), 0);
      chk("t6_arg", int'(instr_operand), 0);
      chk("t6_ipc", int'(instr_pc), 0);
      chk("t6_busy", int'(busy), 0);
      enable = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_pc = 8'h00;
      run_seq(1, 1'b0);

      // randomized programs with random back-pressure and random flushes
      for (int it = 0; it < 12; it++) begin
         run_seq(int'($urandom_range(1, 6)), 1'b1);
         instr_ready = 1'b0;
         enable = 1'b1;
         repeat ($urandom_range(0, 7)) tick();
         redirect = 1'b1;
         redirect_pc = 8'($urandom);
         enable = 1'b0;
         tick();
         redirect = 1'b0;
         chk("rf_valid", int'(instr_valid), 0);
         chk("rf_busy", int'(busy), 0);
         model_pc = redirect_pc;
      end
      run_seq(3, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
